sm_regdump_tx: RTL and testbench
================================

Name: sm_regdump_tx

Overview:
- Hardware register-dump transmitter for sm_top. The bench trace monitors CPU state from inside simulation; this block exports the same state off-chip, on silicon, with no debugger.
- On a start pulse it walks the register-file debug port (regAddr/regData) from x0 to x31 and streams every 32-bit value over an 8N1 UART TX line, preceded by a sync byte.
- It sits beside sm_cpu in sm_top and owns the regAddr input of the debug read port.

Parameters:
- BAUD_DIV, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- SYNC_BYTE, 8'hA5, header byte sent before register data.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a dump; sampled on rising clk.
- regAddr  out  5  register index presented to the CPU debug read port.
- regData  in  32  combinational read data for regAddr.
- tx  out  1  UART serial output; idle high.
- busy  out  1  high from the cycle after start is accepted until the dump completes.
- done  out  1  one-cycle pulse when the last stop bit ends.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - tx=1, busy=0, done=0, regAddr=0.
  - State=IDLE; baud counter, bit counter, byte counter and register index all clear.
  - Reset asserted mid-frame aborts the dump immediately.
  - No partial frame resumes after rst_n rises.
- FSM states:
  - IDLE, SYNC, ADDR, LATCH, START, DATA, STOP, DONE.
- IDLE:
  - start=1 at edge T -> state SYNC, busy=1 at T+1.
  - start while busy is ignored; no queuing.
- SYNC:
  - Loads SYNC_BYTE into the shift register, then sends it as a normal frame (START/DATA/STOP).
  - After its stop bit -> ADDR with index=0.
- ADDR (1 cycle):
  - regAddr=index.
- LATCH (1 cycle):
  - Captures regData into a 32-bit word register.
  - regData is therefore sampled one full cycle after regAddr changes.
  - Byte counter=0.
- Byte order:
  - Word bytes are sent most-significant byte first: [31:24], [23:16], [15:8], [7:0].
- Frame format:
  - START: tx=0 for BAUD_DIV cycles.
  - DATA: 8 bits LSB first, each held BAUD_DIV cycles.
  - STOP: tx=1 for BAUD_DIV cycles.
  - tx is a registered output, so changes are glitch-free.
- Frame sequencing:
  - No idle gap between frames: the next START follows the previous STOP directly.
  - The ADDR/LATCH cycles are inserted only before byte 0 of each word. During those cycles tx stays 1, which extends the preceding stop bit by 2 cycles.
- After byte 3 of a word:
  - If index<31: index increments, then ADDR.
  - If index=31: DONE. There is no wrap to 0.
- DONE (1 cycle):
  - done=1, busy=0 in this cycle, then IDLE.
  - A start in the DONE cycle is ignored.
  - A start in the following cycle is accepted.
- Baud counter:
  - Counts 0..BAUD_DIV-1 and advances the bit on terminal count.
  - Width is $clog2(BAUD_DIV); wrap-around never reaches an out-of-range value.
- Dump length:
  - 129 frames = 1290*BAUD_DIV cycles of frame time, plus 64 ADDR/LATCH cycles, plus the SYNC entry cycle.
- regAddr:
  - Holds its last value while IDLE; it is 31 after a completed dump.
- Register x0:
  - Dumped as whatever regData returns for regAddr=0 (0 on a correct CPU). The block does not special-case it.

Test Plan:
- Reset idle: hold rst_n=0 for 4 cycles, then release with no start for 100 cycles -> tx=1, busy=0, done=0, regAddr=0 throughout.
- Full dump with BAUD_DIV=4 and regData model = 32'h1000_0000|regAddr:
  - Decode tx -> bytes A5, 10 00 00 00, 10 00 00 01, ..., 10 00 00 1F (129 bytes).
  - Every bit is exactly 4 cycles wide.
  - done pulses once; busy is high for 1290*4+64+1 cycles.
- Latch timing: regData model = {27'b0,regAddr} delayed combinationally, with regData changing only on regAddr change -> each word equals its index. This proves sampling occurs in LATCH, not ADDR.
- Start while busy: pulse start again at frame 10 -> no restart, byte sequence unchanged, single done pulse.
- Reset mid-operation: assert rst_n=0 during DATA of frame 40 -> tx=1 asynchronously and busy=0. A new start afterwards yields a fresh stream beginning with A5.
- Back-to-back: pulse start in the cycle after done -> second identical 129-byte stream; a start in the done cycle itself is ignored.

Source files
------------

// File: rtl/sm_regdump_tx_if.sv
// Bus bundle between the register-dump transmitter and its surroundings:
// start/busy/done handshake, the CPU debug read port and the UART line.
interface sm_regdump_tx_if;
  logic        start;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic        tx;
  logic        busy;
  logic        done;

  // Side that requests dumps, provides register data and listens to tx
  modport master (
    output start, regData,
    input  regAddr, tx, busy, done
  );

  // The transmitter itself
  modport slave (
    input  start, regData,
    output regAddr, tx, busy, done
  );
endinterface

// File: rtl/sm_regdump_tx.sv
// Register-dump transmitter: on a start pulse, sends a sync byte followed by
// registers x0..x31 (MSB byte first) as back-to-back 8N1 UART frames.
module sm_regdump_tx #(
  parameter int         BAUD_DIV  = 434,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic           clk,
  input  logic           rst_n,
  sm_regdump_tx_if.slave bus
);

  localparam int            CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, SYNC, ADDR, LATCH, START, DATA, STOP, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baudCnt_q, baudCnt_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [1:0]    byteCnt_q, byteCnt_d;
  logic [4:0]    regAddr_q, regAddr_d;
  logic [23:0]   word_q, word_d;
  logic [7:0]    byte_q, byte_d;
  logic          hdr_q, hdr_d;
  logic          tx_q, tx_d;
  logic          baudTc;

  assign baudTc = (baudCnt_q == BAUD_LAST);

  // State and datapath registers; reset aborts any frame and idles the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baudCnt_q <= '0;
      bitCnt_q  <= '0;
      byteCnt_q <= '0;
      regAddr_q <= '0;
      word_q    <= '0;
      byte_q    <= '0;
      hdr_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      bitCnt_q  <= bitCnt_d;
      byteCnt_q <= byteCnt_d;
      regAddr_q <= regAddr_d;
      word_q    <= word_d;
      byte_q    <= byte_d;
      hdr_q     <= hdr_d;
      tx_q      <= tx_d;
    end
  end

  // Next-state logic: frame sequencing, byte/word walk and the registered tx level
  always_comb begin
    state_d   = state_q;
    baudCnt_d = baudCnt_q;
    bitCnt_d  = bitCnt_q;
    byteCnt_d = byteCnt_q;
    regAddr_d = regAddr_q;
    word_d    = word_q;
    byte_d    = byte_q;
    hdr_d     = hdr_q;

    case (state_q)
      IDLE: begin
        if (bus.start) state_d = SYNC;
      end
      SYNC: begin
        byte_d    = SYNC_BYTE;
        hdr_d     = 1'b1;
        baudCnt_d = '0;
        state_d   = START;
      end
      ADDR: begin
        state_d = LATCH;
      end
      LATCH: begin
        byte_d    = bus.regData[31:24];
        word_d    = bus.regData[23:0];
        byteCnt_d = 2'd0;
        hdr_d     = 1'b0;
        baudCnt_d = '0;
        state_d   = START;
      end
      START: begin
        if (baudTc) begin
          baudCnt_d = '0;
          bitCnt_d  = 3'd0;
          state_d   = DATA;
        end else begin
          baudCnt_d = baudCnt_q + CW'(1);
        end
      end
      DATA: begin
        if (baudTc) begin
          baudCnt_d = '0;
          if (bitCnt_q == 3'd7) state_d = STOP;
          else                  bitCnt_d = bitCnt_q + 3'd1;
        end else begin
          baudCnt_d = baudCnt_q + CW'(1);
        end
      end
      STOP: begin
        if (baudTc) begin
          baudCnt_d = '0;
          if (hdr_q) begin
            regAddr_d = 5'd0;
            state_d   = ADDR;
          end else if (byteCnt_q != 2'd3) begin
            byteCnt_d = byteCnt_q + 2'd1;
            byte_d    = word_q[23:16];
            word_d    = {word_q[15:0], 8'h00};
            state_d   = START;
          end else if (regAddr_q == 5'd31) begin
            state_d = DONE;
          end else begin
            regAddr_d = regAddr_q + 5'd1;
            state_d   = ADDR;
          end
        end else begin
          baudCnt_d = baudCnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = byte_d[bitCnt_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.regAddr = regAddr_q;
  assign bus.tx      = tx_q;
  assign bus.busy    = (state_q != IDLE) && (state_q != DONE);
  assign bus.done    = (state_q == DONE);

endmodule

// File: tb/tb_sm_regdump_tx.sv
// Directed bench for sm_regdump_tx: decodes the UART stream and checks bytes,
// bit widths, busy/done timing, restart rules and asynchronous reset.
module tb_sm_regdump_tx;

  localparam int BAUD        = 4;
  localparam int NBYTES      = 129;
  localparam int BUSY_CYCLES = 1290 * BAUD + 64 + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;
  int          dataMode = 0;
  logic [31:0] delayedData = 32'h0;
  int          busyCycles = 0;
  int          donePulses = 0;

  sm_regdump_tx_if bus ();

  sm_regdump_tx #(.BAUD_DIV(BAUD), .SYNC_BYTE(8'hA5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Slow read port: data follows regAddr only after 12 ns (over one cycle)
  always @(bus.regAddr) begin
    #12;
    delayedData = {27'b0, bus.regAddr};
  end

  assign bus.regData = (dataMode == 0) ? (32'h1000_0000 | {27'b0, bus.regAddr})
                                       : delayedData;

  // Running busy-cycle and done-pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (bus.busy === 1'b1) busyCycles++;
    if (bus.done === 1'b1) donePulses++;
  end

  function automatic logic [7:0] expByte(input int mode, input int k);
    logic [31:0] word;
    int w, b;
    if (k == 0) return 8'hA5;
    w = (k - 1) / 4;
    b = (k - 1) % 4;
    word = (mode == 0) ? (32'h1000_0000 | 32'(w)) : 32'(w);
    return word[31 - 8*b -: 8];
  endfunction

  task automatic startPulse();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic recvByte(output logic [7:0] b, output bit fmtOk, output bit timedOut);
    logic [39:0] s;
    logic [3:0]  grp;
    int n;
    b = 8'h00; fmtOk = 1'b0; timedOut = 1'b0; s = '0; n = 0;
    @(negedge clk);
    while (bus.tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      timedOut = 1'b1;
      return;
    end
    s[0] = bus.tx;
    for (int i = 1; i < 40; i++) begin
      @(negedge clk);
      s[i] = bus.tx;
    end
    fmtOk = (s[3:0] == 4'h0) && (s[39:36] == 4'hF);
    for (int k = 0; k < 8; k++) begin
      grp = s[4 + 4*k +: 4];
      if (grp != 4'h0 && grp != 4'hF) fmtOk = 1'b0;
      b[k] = grp[0];
    end
  endtask

  task automatic recvStream(input int mode, input int first, input int last, input string tag);
    logic [7:0] b;
    bit ok, to;
    for (int k = first; k <= last; k++) begin
      recvByte(b, ok, to);
      checks++;
      if (to) begin
        errors++;
        $display("[TB] FAIL %s frame %0d: no start bit seen, expected byte %h", tag, k, expByte(mode, k));
        return;
      end
      if (!ok) begin
        errors++;
        $display("[TB] FAIL %s frame %0d: bit timing/format wrong, expected %0d-cycle bits", tag, k, BAUD);
      end
      checks++;
      if (b !== expByte(mode, k)) begin
        errors++;
        $display("[TB] FAIL %s byte %0d: got %h expected %h", tag, k, b, expByte(mode, k));
      end
    end
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    while (bus.done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s done: got %b expected 1 within 50 cycles", tag, bus.done);
    end
  endtask

  task automatic checkBusyRise(input string tag);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s busy after start: got %b expected 1", tag, bus.busy);
    end
  endtask

  task automatic checkDumpEnd(input string tag, input int b0, input int d0, input int nDumps);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s busy in done cycle: got %b expected 0", tag, bus.busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (donePulses - d0 !== nDumps) begin
      errors++;
      $display("[TB] FAIL %s done pulses: got %0d expected %0d", tag, donePulses - d0, nDumps);
    end
    checks++;
    if (busyCycles - b0 !== nDumps * BUSY_CYCLES) begin
      errors++;
      $display("[TB] FAIL %s busy cycles: got %0d expected %0d", tag, busyCycles - b0, nDumps * BUSY_CYCLES);
    end
    checks++;
    if (bus.regAddr !== 5'd31) begin
      errors++;
      $display("[TB] FAIL %s final regAddr: got %0d expected 31", tag, bus.regAddr);
    end
  endtask

  task automatic test_reset();
    bit badTx = 0, badBusy = 0, badDone = 0, badAddr = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.regAddr !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset outputs: tx=%b busy=%b done=%b regAddr=%0d expected 1/0/0/0",
               bus.tx, bus.busy, bus.done, bus.regAddr);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) badTx = 1;
      if (bus.busy !== 1'b0) badBusy = 1;
      if (bus.done !== 1'b0) badDone = 1;
      if (bus.regAddr !== 5'd0) badAddr = 1;
    end
    checks += 4;
    if (badTx)   begin errors++; $display("[TB] FAIL idle tx: got a 0 expected 1 throughout"); end
    if (badBusy) begin errors++; $display("[TB] FAIL idle busy: got a 1 expected 0 throughout"); end
    if (badDone) begin errors++; $display("[TB] FAIL idle done: got a 1 expected 0 throughout"); end
    if (badAddr) begin errors++; $display("[TB] FAIL idle regAddr: got nonzero expected 0 throughout"); end
  endtask

  task automatic test_full_dump();
    int b0 = busyCycles, d0 = donePulses;
    dataMode = 0;
    startPulse();
    checkBusyRise("full");
    recvStream(0, 0, NBYTES - 1, "full");
    waitDone("full");
    checkDumpEnd("full", b0, d0, 1);
  endtask

  task automatic test_latch_timing();
    int b0 = busyCycles, d0 = donePulses;
    dataMode = 1;
    startPulse();
    checkBusyRise("latch");
    recvStream(1, 0, NBYTES - 1, "latch");
    waitDone("latch");
    checkDumpEnd("latch", b0, d0, 1);
    dataMode = 0;
  endtask

  task automatic test_start_while_busy();
    int b0 = busyCycles, d0 = donePulses;
    startPulse();
    checkBusyRise("busystart");
    recvStream(0, 0, 9, "busystart");
    fork
      begin
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
      end
    join_none
    recvStream(0, 10, NBYTES - 1, "busystart");
    waitDone("busystart");
    checkDumpEnd("busystart", b0, d0, 1);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int b0, d0;
    startPulse();
    recvStream(0, 0, 38, "midreset");
    @(negedge clk);
    while (bus.tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.regAddr !== 5'd0) begin
      errors++;
      $display("[TB] FAIL midreset async: tx=%b busy=%b regAddr=%0d expected 1/0/0",
               bus.tx, bus.busy, bus.regAddr);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset resume: tx=%b busy=%b expected 1/0", bus.tx, bus.busy);
    end
    b0 = busyCycles;
    d0 = donePulses;
    startPulse();
    checkBusyRise("fresh");
    recvStream(0, 0, NBYTES - 1, "fresh");
    waitDone("fresh");
    checkDumpEnd("fresh", b0, d0, 1);
  endtask

  task automatic test_back_to_back();
    int b0 = busyCycles, d0 = donePulses;
    startPulse();
    checkBusyRise("b2b first");
    recvStream(0, 0, NBYTES - 1, "b2b first");
    waitDone("b2b first");
    bus.start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b start in done cycle: busy got %b expected 0", bus.busy);
    end
    @(posedge clk); #1 bus.start = 1'b0;
    checkBusyRise("b2b second");
    recvStream(0, 0, NBYTES - 1, "b2b second");
    waitDone("b2b second");
    checkDumpEnd("b2b", b0, d0, 2);
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_full_dump();
    test_latch_timing();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
